// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared instruction/data memory port.
// Serialises fetch and load/store accesses, with an ack timeout per access.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  output logic                    ls_gnt,
  output logic                    ls_rvalid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                    r_state;
  logic                      r_last_ls;
  logic                      r_owner_ls;
  logic [9:0]                r_cnt;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic [DATA_WIDTH/8-1:0]   r_mem_be;
  logic                      r_if_rvalid;
  logic [DATA_WIDTH-1:0]     r_if_rdata;
  logic                      r_if_err;
  logic                      r_ls_rvalid;
  logic [DATA_WIDTH-1:0]     r_ls_rdata;
  logic                      r_ls_err;
  logic                      w_pick_if;
  logic                      w_pick_ls;
  logic                      w_timeout;

  // On a tie the requester that did not win last time gets the port.
  assign w_pick_if = (r_state == IDLE) && !reset && if_req && (!ls_req || r_last_ls);
  assign w_pick_ls = (r_state == IDLE) && !reset && ls_req && (!if_req || !r_last_ls);
  assign w_timeout = (r_cnt == 10'(TIMEOUT - 1));

  assign if_gnt    = w_pick_if;
  assign ls_gnt    = w_pick_ls;
  assign busy      = (r_state != IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_ls   <= 1'b1;
      r_owner_ls  <= 1'b0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
      r_ls_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
            r_owner_ls  <= 1'b0;
            r_last_ls   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ACCESS;
          end else if (w_pick_ls) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= ls_we;
            r_mem_addr  <= ls_addr;
            r_mem_wdata <= ls_wdata;
            r_mem_be    <= ls_be;
            r_owner_ls  <= 1'b1;
            r_last_ls   <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack on the final timeout cycle still counts as success.
          if (mem_ack || w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= RESP;
            if (r_owner_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
              r_ls_err    <= !mem_ack;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_ack ? mem_rdata : '0;
              r_if_err    <= !mem_ack;
            end
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        RESP: begin
          r_if_rvalid <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ls;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_t;

  typedef struct {
    bit          is_ls;
    logic [31:0] rdata;
    bit          err;
    int          cycles;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got unexpected event, required none", name);
  endfunction

  // Memory model: acks after mem_wait extra ACCESS cycles (-1 = never).
  int          mem_wait = -1;
  logic [31:0] mem_data = '0;
  bit          force_ack = 0;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    mem_rdata = mem_data;
    if (mem_req) begin
      mem_ack = force_ack || (acc_cnt == mem_wait);
      acc_cnt++;
    end else begin
      mem_ack = force_ack;
      acc_cnt = 0;
    end
  end

  // Monitor
  gnt_t cur;
  rsp_t rsp;
  bit   cur_v = 0;
  int   cyc = 0;
  int   age = 0;

  always @(negedge clk) begin
    if (reset) begin
      cur_v = 0;
    end else begin
      if (cur_v) age++;
      if (if_gnt && ls_gnt) flag("double_gnt");
      if (if_gnt || ls_gnt) begin
        if (gq.size() == 0) flag("unexpected_gnt");
        else begin
          cur = gq.pop_front();
          chk("gnt_owner_ls", {31'b0, ls_gnt}, {31'b0, cur.is_ls});
          cur_v = 1; cyc = 0; age = 0;
        end
      end
      if (mem_req) begin
        if (!cur_v) flag("mem_req_no_owner");
        else begin
          cyc++;
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
          chk("mem_be", {28'b0, mem_be}, {28'b0, cur.be});
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (if_rvalid && ls_rvalid) flag("double_rvalid");
      if (if_rvalid || ls_rvalid) begin
        if (rq.size() == 0 || !cur_v) flag("unexpected_rvalid");
        else begin
          rsp = rq.pop_front();
          chk("rvalid_owner_ls", {31'b0, ls_rvalid}, {31'b0, rsp.is_ls});
          chk("rdata", ls_rvalid ? ls_rdata : if_rdata, rsp.rdata);
          chk("err", {31'b0, ls_rvalid ? ls_err : if_err}, {31'b0, rsp.err});
          chk("access_cycles", cyc, rsp.cycles);
          chk("rvalid_latency", age, rsp.cycles + 1);
          $display("txn %s addr=%h rdata=%h err=%0d cycles=%0d",
                   ls_rvalid ? "LS" : "IF", cur.addr,
                   ls_rvalid ? ls_rdata : if_rdata, ls_rvalid ? ls_err : if_err, cyc);
          cur_v = 0;
        end
      end
    end
  end

  task automatic expect_txn(bit is_ls, logic [31:0] addr, bit we, logic [31:0] wdata,
                            logic [3:0] be, logic [31:0] exp_rdata, bit exp_err, int exp_cyc);
    gnt_t g;
    rsp_t r;
    g.is_ls = is_ls; g.addr = addr; g.we = we; g.wdata = wdata; g.be = be;
    r.is_ls = is_ls; r.rdata = exp_rdata; r.err = exp_err; r.cycles = exp_cyc;
    gq.push_back(g);
    rq.push_back(r);
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after the grant edge.
  task automatic issue(bit is_ls, logic [31:0] addr, bit we, logic [31:0] wdata,
                       logic [3:0] be, int wt, logic [31:0] mdata,
                       logic [31:0] exp_rdata, bit exp_err, int exp_cyc);
    bit got = 0;
    expect_txn(is_ls, addr, is_ls ? we : 1'b0, wdata, is_ls ? be : 4'hF,
               exp_rdata, exp_err, exp_cyc);
    mem_wait = wt;
    mem_data = mdata;
    if (is_ls) begin
      ls_req = 1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_be = be;
    end else begin
      if_req = 1; if_addr = addr;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = is_ls ? ls_gnt : if_gnt;
    end
    if (!got) flag("gnt_timeout");
    @(posedge clk); #1;
    if_req = 0; ls_req = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      done = !busy && (rq.size() == 0);
    end
    if (!done) flag("idle_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    int ng;
    reset = 1; if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk); #1;

    // Contention with zero-wait memory: IF wins first after reset, then strict alternation.
    mem_wait = 0; mem_data = 32'h1111_2222;
    for (int k = 0; k < 2; k++) begin
      expect_txn(0, 32'h40, 0, 32'h0, 4'hF, 32'h1111_2222, 0, 1);
      expect_txn(1, 32'h80, 0, 32'h0, 4'hF, 32'h1111_2222, 0, 1);
    end
    if_addr = 32'h40; ls_addr = 32'h80; ls_we = 0; ls_be = 4'hF;
    if_req = 1; ls_req = 1;
    ng = 0;
    for (int i = 0; i < 100 && ng < 4; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) ng++;
    end
    if (ng < 4) flag("contention_gnt_timeout");
    @(posedge clk); #1;
    if_req = 0; ls_req = 0;
    wait_idle();

    // Zero-wait fetch
    issue(0, 32'h0000_0010, 0, 32'h0, 4'h0, 0, 32'h00A0_0093, 32'h00A0_0093, 0, 1);
    wait_idle();
    // Store with 4 ACCESS cycles; load data must read back as 0
    issue(1, 32'h100, 1, 32'hDEAD_BEEF, 4'h3, 3, 32'h1234_5678, 32'h0, 0, 4);
    wait_idle();
    // Load with 3 ACCESS cycles
    issue(1, 32'h104, 0, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 3);
    wait_idle();
    // Timeout: no ack ever, 8 ACCESS cycles then error
    issue(1, 32'h200, 0, 32'h0, 4'hF, -1, 32'hFFFF_FFFF, 32'h0, 1, 8);
    wait_idle();
    // Ack arriving on the timeout cycle is a success
    issue(0, 32'h208, 0, 32'h0, 4'h0, 7, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 0, 8);
    wait_idle();

    // Spurious ack while idle
    force_ack = 1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_mem_req", {31'b0, mem_req}, 32'd0);
      chk("spur_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    force_ack = 0;

    // Reset during the 2nd ACCESS cycle drops the transaction
    issue(0, 32'h300, 0, 32'h0, 4'h0, -1, 32'h5555_AAAA, 32'h0, 0, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    rq.delete();
    gq.delete();
    force_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rstmid_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    force_ack = 0;
    issue(0, 32'h304, 0, 32'h0, 4'h0, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0, 1);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("gq_empty", gq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single unified instruction/data memory port between two requesters. The fetch requester issues instruction reads during FETCH; the load/store requester issues data reads and writes during MEMREAD/MEMWRITE. The block sits between the multicycle core control/datapath and the external memory. It serialises accesses, handles variable-latency memory acknowledgement with a timeout, and returns read data and completion to the granted requester.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses (byte enables are DATA_WIDTH/8 bits)
TIMEOUT, 255, number of ACCESS cycles without mem_ack before abort; range 1..1023

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch request accepted (combinational, one cycle)
if_rvalid  out  1  fetch complete, one-cycle pulse
if_rdata  out  DATA_WIDTH  fetched word, valid with if_rvalid
if_err  out  1  fetch aborted by timeout, valid with if_rvalid
ls_req  in  1  load/store request; held until ls_gnt
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_WIDTH  data address
ls_wdata  in  DATA_WIDTH  store data
ls_be  in  DATA_WIDTH/8  store byte enables
ls_gnt  out  1  load/store request accepted (combinational, one cycle)
ls_rvalid  out  1  load/store complete, one-cycle pulse
ls_rdata  out  DATA_WIDTH  load data (0 for writes)
ls_err  out  1  load/store aborted by timeout, valid with ls_rvalid
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_WIDTH  memory address, registered
mem_wdata  out  DATA_WIDTH  memory write data, registered
mem_be  out  DATA_WIDTH/8  memory byte enables, registered (all ones for fetch)
mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0; last_grant = LS, so IF wins the first tie. Reset mid-transaction drops the transaction: mem_req is 0 the cycle after reset, and no rvalid is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Winner selection: if only one req is high, that requester wins. If both are high, the requester not equal to last_grant wins (round-robin).
  - The winner's gnt is high combinationally in this cycle.
  - At the clock edge: latch the winner's fields into mem_*. Fetch forces mem_we = 0 and mem_be = all ones. Set mem_req = 1, record owner, update last_grant, clear the counter, and go to ACCESS.
  - No req: stay in IDLE with gnt = 0.
- ACCESS:
  - mem_req and all mem_* fields are held stable.
  - mem_ack = 1: capture mem_rdata into the owner's rdata (0 if mem_we), set err = 0, mem_req = 0, go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and there is no ack: mem_req = 0, owner rdata = 0, err = 1, go to RESP.
  - An ack arriving on the timeout cycle counts as success.
- RESP:
  - The owner's rvalid is high for exactly one cycle; rdata/err are held until the next RESP.
  - The non-owner's rvalid stays 0.
  - Next state is IDLE. No grant is given in RESP.
- Latency with zero-wait memory (ack in the first ACCESS cycle): gnt in cycle 0, mem_req in cycle 1, rvalid in cycle 2. Minimum of 3 cycles per transaction.
- mem_ack outside ACCESS is ignored.
- A requester dropping req before gnt is legal; no transaction results.
- req changing after gnt has no effect on the in-flight access.
- Starvation bound: under continuous contention, grants strictly alternate IF, LS, IF, LS.

Test Plan:
- Zero-wait fetch: if_req = 1, if_addr = 0x0000_0010, mem_ack held 1, mem_rdata = 0x00A0_0093 -> if_gnt cycle 0; mem_req = 1, mem_addr = 0x10, mem_be = 0xF in cycle 1; if_rvalid = 1, if_rdata = 0x00A0_0093, if_err = 0 in cycle 2.
- Store with wait states: ls_req, ls_we = 1, ls_addr = 0x100, ls_wdata = 0xDEADBEEF, ls_be = 0x3, mem_ack after 4 ACCESS cycles -> mem_* stable for 4 cycles; ls_rvalid = 1 one cycle after ack; ls_rdata = 0; if_rvalid never asserts.
- Contention: if_req and ls_req both held high from reset, zero-wait memory -> grant order IF, LS, IF, LS; each rvalid pulse goes to the matching owner.
- Timeout: TIMEOUT = 8, ls read with mem_ack never asserted -> mem_req drops after 8 ACCESS cycles; ls_rvalid = 1, ls_err = 1, ls_rdata = 0; busy returns to 0.
- Reset mid-access: reset pulsed during the 2nd ACCESS cycle, then mem_ack = 1 -> mem_req = 0 and busy = 0 after reset; no rvalid pulse; the next if_req is granted normally.
- Spurious ack: mem_ack = 1 while in IDLE with no req -> no rvalid, no state change, mem_req stays 0.
